// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and pipeline-register controls; master = pipeline, slave = hazard unit
interface hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 16
);
  logic id_ex_mem_read;
  logic id_ex_reg_write;
  logic [REG_AW-1:0] id_ex_rd;
  logic ex_mem_reg_write;
  logic [REG_AW-1:0] ex_mem_rd;
  logic [NUM_SRC*REG_AW-1:0] if_id_rs;
  logic [NUM_SRC-1:0] if_id_rs_valid;
  logic dmem_req;
  logic dmem_done;
  logic redirect;
  logic perf_clr;
  logic pc_write;
  logic if_id_write;
  logic id_ex_write;
  logic ex_mem_write;
  logic id_ex_bubble;
  logic if_id_flush;
  logic id_ex_flush;
  logic mem_wait;
  logic [CNT_W-1:0] loaduse_cnt;
  logic [CNT_W-1:0] memwait_cnt;
  modport master (
    output id_ex_mem_read, id_ex_reg_write, id_ex_rd, ex_mem_reg_write, ex_mem_rd,
           if_id_rs, if_id_rs_valid, dmem_req, dmem_done, redirect, perf_clr,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
           if_id_flush, id_ex_flush, mem_wait, loaduse_cnt, memwait_cnt
  );
  modport slave (
    input  id_ex_mem_read, id_ex_reg_write, id_ex_rd, ex_mem_reg_write, ex_mem_rd,
           if_id_rs, if_id_rs_valid, dmem_req, dmem_done, redirect, perf_clr,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
           if_id_flush, id_ex_flush, mem_wait, loaduse_cnt, memwait_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use/RAW stall, memory freeze FSM, redirect flush, saturating stall counters; ports clk, rst_n, bus (hazard_ctrl_if.slave)
module hazard_ctrl_unit #(
  parameter int REG_AW = 3,
  parameter int NUM_SRC = 2,
  parameter int FWD_EN = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_nx;
  logic [NUM_SRC-1:0] hit_ex, hit_mem;
  logic data_haz, mem_stall, sel_redir, sel_haz;
  logic [CNT_W-1:0] lu_cnt, mw_cnt;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign hit_ex[i] = bus.if_id_rs_valid[i] & (bus.if_id_rs[i*REG_AW +: REG_AW] == bus.id_ex_rd);
    assign hit_mem[i] = bus.if_id_rs_valid[i] & (bus.if_id_rs[i*REG_AW +: REG_AW] == bus.ex_mem_rd);
  end
  always_comb begin
    data_haz = (FWD_EN != 0) ? (bus.id_ex_mem_read & bus.id_ex_reg_write & |hit_ex)
                             : ((bus.id_ex_reg_write & |hit_ex) | (bus.ex_mem_reg_write & |hit_mem));
    mem_stall = (state == MEM_WAIT) | (bus.dmem_req & ~bus.dmem_done);
    sel_redir = ~mem_stall & bus.redirect;
    sel_haz = ~mem_stall & ~bus.redirect & data_haz;
    state_nx = (state == RUN) ? ((bus.dmem_req & ~bus.dmem_done) ? MEM_WAIT : RUN)
                              : (bus.dmem_done ? RUN : MEM_WAIT);
    bus.pc_write = rst_n & ~mem_stall & ~sel_haz;
    bus.if_id_write = rst_n & ~mem_stall & ~sel_haz;
    bus.id_ex_write = rst_n & ~mem_stall;
    bus.ex_mem_write = rst_n & ~mem_stall;
    bus.id_ex_bubble = ~rst_n | sel_haz;
    bus.if_id_flush = rst_n & sel_redir;
    bus.id_ex_flush = rst_n & sel_redir;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      lu_cnt <= '0;
      mw_cnt <= '0;
    end else begin
      state <= state_nx;
      lu_cnt <= bus.perf_clr ? '0 : lu_cnt + CNT_W'(sel_haz & ~&lu_cnt);
      mw_cnt <= bus.perf_clr ? '0 : mw_cnt + CNT_W'(mem_stall & ~&mw_cnt);
    end
  assign bus.mem_wait = (state == MEM_WAIT);
  assign bus.loaduse_cnt = lu_cnt;
  assign bus.memwait_cnt = mw_cnt;
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage core. It covers load-use detection over NUM_SRC decode sources and optional full-RAW stalling when forwarding is disabled. It adds multi-cycle data-memory freeze through a RUN/MEM_WAIT state machine, branch-redirect flush, and saturating stall performance counters. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enables, bubble and flush controls.

Parameters:
REG_AW, 3, register-specifier width
NUM_SRC, 2, number of source specifiers checked in IF/ID
FWD_EN, 1, 1 = forwarding present (stall on load-use only); 0 = stall on any RAW against ID/EX or EX/MEM
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_reg_write  in  1  instruction in EX writes a register
id_ex_rd  in  REG_AW  destination of instruction in EX
ex_mem_reg_write  in  1  instruction in MEM writes a register
ex_mem_rd  in  REG_AW  destination of instruction in MEM
if_id_rs  in  NUM_SRC*REG_AW  decode source specifiers; source i = bits [i*REG_AW +: REG_AW]
if_id_rs_valid  in  NUM_SRC  per-source valid
dmem_req  in  1  MEM stage has an access in flight this cycle
dmem_done  in  1  memory access completes this cycle
redirect  in  1  taken branch/jump resolved in EX
perf_clr  in  1  synchronous clear of counters
pc_write  out  1  PC write enable
if_id_write  out  1  IF/ID write enable
id_ex_write  out  1  ID/EX write enable
ex_mem_write  out  1  EX/MEM write enable
id_ex_bubble  out  1  insert NOP control into ID/EX
if_id_flush  out  1  squash IF/ID
id_ex_flush  out  1  squash ID/EX
mem_wait  out  1  FSM is in MEM_WAIT
loaduse_cnt  out  CNT_W  cycles stalled for data hazards
memwait_cnt  out  CNT_W  cycles frozen for memory

Behaviour:
- Reset (rst_n low, asynchronous): FSM to RUN. Counters 0. mem_wait=0. All write enables 0, id_ex_bubble=1, flushes 0, held while rst_n low. Reset during MEM_WAIT returns to RUN unconditionally.
- Source match i: if_id_rs_valid[i] & (rs_i == rd) for the relevant stage. R0 is an ordinary register; no special case.
- data_haz:
  - FWD_EN=1: id_ex_mem_read & id_ex_reg_write & any match against id_ex_rd.
  - FWD_EN=0: (id_ex_reg_write & any match against id_ex_rd) | (ex_mem_reg_write & any match against ex_mem_rd).
- mem_stall = (state==MEM_WAIT) | (dmem_req & ~dmem_done).
- FSM, RUN -> MEM_WAIT: when dmem_req & ~dmem_done.
- FSM, MEM_WAIT -> RUN: on dmem_done. dmem_req is ignored in MEM_WAIT (held by the frozen stage).
- Single-cycle access (dmem_req & dmem_done together) causes no freeze.
- Output priority, highest first; all outputs are combinational from state and inputs:
  1. mem_stall: all four write enables 0, bubble 0, flushes 0. redirect and data_haz are ignored; EX is frozen, so redirect re-presents after the freeze.
  2. redirect: all write enables 1, if_id_flush=1, id_ex_flush=1, bubble 0. data_haz is ignored because the dependent instruction is squashed.
  3. data_haz: pc_write=0, if_id_write=0, id_ex_write=1, ex_mem_write=1, id_ex_bubble=1.
  4. Otherwise: all write enables 1, bubble 0, flushes 0.
- Counters:
  - loaduse_cnt increments in cycles where priority 3 is selected.
  - memwait_cnt increments in cycles where mem_stall=1, including the entering cycle.
  - Both saturate at all-ones; no wrap.
  - perf_clr zeroes both at the next edge; clear wins over increment in the same cycle.
- mem_wait = registered state (1 in MEM_WAIT).
- Latency: detection is combinational, same cycle. The state change is visible from the next edge.
- A back-to-back load-use stall repeats each cycle only while the condition holds. The single bubble normally resolves it with FWD_EN=1. With FWD_EN=0, up to 2 bubbles occur.

Test Plan:
1. Load-use: id_ex_mem_read=1, id_ex_reg_write=1, id_ex_rd=3, rs0=3 valid -> pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle, loaduse_cnt=1. The same case with rs_valid[0]=0 -> no stall.
2. FWD_EN=0: EX writes r5 (no load), decode rs1=5 -> bubble. Next cycle the same instruction is in MEM with ex_mem_rd=5 -> bubble again. Then release; 2 stall cycles total.
3. Memory freeze: dmem_req=1 with dmem_done low for 3 cycles, then high -> mem_wait=1 for cycles 2-4, all enables 0 for 4 cycles, memwait_cnt=4, back to RUN. dmem_req&dmem_done in one cycle -> no freeze.
4. Priority: redirect with data_haz -> flushes=1, pc_write=1, bubble=0. Redirect during MEM_WAIT -> freeze only; redirect honoured in the cycle after dmem_done.
5. Counters: force loaduse_cnt toward saturation with CNT_W=4 -> stays 15. Assert perf_clr concurrent with an increment -> 0.
6. Assert rst_n low mid-MEM_WAIT -> state RUN, counters 0, bubble=1 and enables 0 immediately (asynchronous). On release, normal operation resumes.
